// File: rtl/control_mem_block_pkg.sv
// Shared opcode, funct and ALU-control constants for the control/memory slice.
// Also holds the packed control-word type used by the decoder.
package control_mem_block_pkg;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpAddi  = 6'b001000;
   localparam logic [5:0] OpAndi  = 6'b001100;
   localparam logic [5:0] OpOri   = 6'b001101;
   localparam logic [5:0] OpSlti  = 6'b001010;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpJal   = 6'b000011;

   localparam logic [5:0] FnAdd = 6'b100000;
   localparam logic [5:0] FnSub = 6'b100010;
   localparam logic [5:0] FnAnd = 6'b100100;
   localparam logic [5:0] FnOr  = 6'b100101;
   localparam logic [5:0] FnNor = 6'b100111;
   localparam logic [5:0] FnSlt = 6'b101010;
   localparam logic [5:0] FnJr  = 6'b001000;

   typedef enum logic [3:0] {
      AluAnd = 4'b0000,
      AluOr  = 4'b0001,
      AluAdd = 4'b0010,
      AluSub = 4'b0110,
      AluSlt = 4'b0111,
      AluNor = 4'b1100
   } alu_op_e;

   typedef struct packed {
      logic    reg_write;
      logic    reg_dst;
      logic    alu_src;
      logic    branch;
      logic    mem_write;
      logic    mem_to_reg;
      logic    jump;
      logic    jal;
      logic    jr;
      alu_op_e alu_ctrl;
   } ctrl_t;

   localparam ctrl_t CtrlNone = '{
      reg_write:  1'b0,
      reg_dst:    1'b0,
      alu_src:    1'b0,
      branch:     1'b0,
      mem_write:  1'b0,
      mem_to_reg: 1'b0,
      jump:       1'b0,
      jal:        1'b0,
      jr:         1'b0,
      alu_ctrl:   AluAdd
   };

   // Only meaningful for the six arithmetic/logic R-type functs.
   function automatic alu_op_e funct_to_alu(input logic [5:0] funct);
      alu_op_e res;
      case (funct)
         FnSub:   res = AluSub;
         FnAnd:   res = AluAnd;
         FnOr:    res = AluOr;
         FnNor:   res = AluNor;
         FnSlt:   res = AluSlt;
         default: res = AluAdd;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/control_mem_block_data_memory_array.sv
// Word-addressed data storage: asynchronous read, synchronous write and
// synchronous active-low clear of every word.
module data_memory_array #(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 64
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] addr,
   input  logic [N-1:0]             wdata,
   output logic [N-1:0]             rdata
);

   logic [N-1:0] mem [DEPTH];

   // Clear wins over a write issued on the same edge.
   always_ff @(posedge CLK) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/control_mem_block.sv
// Single-cycle MIPS-style main/ALU decoder, branch-target adder and data memory.
// Decode and branch logic are purely combinational and unaffected by reset.
module control_mem_block
   import control_mem_block_pkg::*;
#(
   parameter int unsigned N     = 32,
   parameter int unsigned DEPTH = 64
) (
   input  logic         CLK,
   input  logic         rst,
   input  logic [5:0]   op,
   input  logic [5:0]   funct,
   input  logic         zero_flag,
   input  logic [N-1:0] pc_plus_4,
   input  logic [N-1:0] signimm,
   input  logic [N-1:0] alu_out,
   input  logic [N-1:0] write_data,
   output logic         reg_write,
   output logic         reg_dst,
   output logic         alu_src,
   output logic         branch,
   output logic         mem_write,
   output logic         mem_to_reg,
   output logic         jump,
   output logic         jal,
   output logic         jr,
   output logic [3:0]   alu_ctrl,
   output logic [N-1:0] pc_branch,
   output logic         pc_src,
   output logic [N-1:0] read_data
);

   localparam int unsigned AW = $clog2(DEPTH);

   ctrl_t ctrl;

   always_comb begin
      ctrl = CtrlNone;
      case (op)
         OpRtype: begin
            case (funct)
               FnAdd, FnSub, FnAnd, FnOr, FnNor, FnSlt: begin
                  ctrl.reg_write = 1'b1;
                  ctrl.reg_dst   = 1'b1;
                  ctrl.alu_ctrl  = funct_to_alu(funct);
               end
               FnJr:    ctrl.jr = 1'b1;
               default: ;
            endcase
         end
         OpLw: begin
            ctrl.reg_write  = 1'b1;
            ctrl.alu_src    = 1'b1;
            ctrl.mem_to_reg = 1'b1;
         end
         OpSw: begin
            ctrl.alu_src   = 1'b1;
            ctrl.mem_write = 1'b1;
         end
         OpBeq: begin
            ctrl.branch   = 1'b1;
            ctrl.alu_ctrl = AluSub;
         end
         OpAddi, OpAndi, OpOri, OpSlti: begin
            ctrl.reg_write = 1'b1;
            ctrl.alu_src   = 1'b1;
            case (op)
               OpAndi:  ctrl.alu_ctrl = AluAnd;
               OpOri:   ctrl.alu_ctrl = AluOr;
               OpSlti:  ctrl.alu_ctrl = AluSlt;
               default: ctrl.alu_ctrl = AluAdd;
            endcase
         end
         OpJ: ctrl.jump = 1'b1;
         OpJal: begin
            ctrl.jump      = 1'b1;
            ctrl.jal       = 1'b1;
            ctrl.reg_write = 1'b1;
         end
         default: ;
      endcase
   end

   assign reg_write  = ctrl.reg_write;
   assign reg_dst    = ctrl.reg_dst;
   assign alu_src    = ctrl.alu_src;
   assign branch     = ctrl.branch;
   assign mem_write  = ctrl.mem_write;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign jump       = ctrl.jump;
   assign jal        = ctrl.jal;
   assign jr         = ctrl.jr;
   assign alu_ctrl   = ctrl.alu_ctrl;

   assign pc_branch = pc_plus_4 + (signimm << 2);
   assign pc_src    = ctrl.branch & zero_flag;

   // Byte offset and bits above the array are dropped, so addresses alias.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{alu_out[N-1:AW+2], alu_out[1:0]};

   data_memory_array #(
      .N     (N),
      .DEPTH (DEPTH)
   ) u_dmem (
      .CLK   (CLK),
      .rst   (rst),
      .we    (ctrl.mem_write),
      .addr  (alu_out[AW+1:2]),
      .wdata (write_data),
      .rdata (read_data)
   );

endmodule

// File: tb/tb_control_mem_block.sv
// Randomized bench for control_mem_block: a table-driven decode model plus a
// plain word-array memory model, compared against the DUT every cycle.
module tb_control_mem_block;

   localparam int N     = 32;
   localparam int DEPTH = 64;

   logic          CLK;
   logic          rst;
   logic [5:0]    op;
   logic [5:0]    funct;
   logic          zero_flag;
   logic [N-1:0]  pc_plus_4;
   logic [N-1:0]  signimm;
   logic [N-1:0]  alu_out;
   logic [N-1:0]  write_data;
   logic          reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg;
   logic          jump, jal, jr;
   logic [3:0]    alu_ctrl;
   logic [N-1:0]  pc_branch;
   logic          pc_src;
   logic [N-1:0]  read_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [N-1:0] model_mem [DEPTH];
   logic         model_ready = 1'b0;

   control_mem_block #(
      .N     (N),
      .DEPTH (DEPTH)
   ) dut (
      .CLK        (CLK),
      .rst        (rst),
      .op         (op),
      .funct      (funct),
      .zero_flag  (zero_flag),
      .pc_plus_4  (pc_plus_4),
      .signimm    (signimm),
      .alu_out    (alu_out),
      .write_data (write_data),
      .reg_write  (reg_write),
      .reg_dst    (reg_dst),
      .alu_src    (alu_src),
      .branch     (branch),
      .mem_write  (mem_write),
      .mem_to_reg (mem_to_reg),
      .jump       (jump),
      .jal        (jal),
      .jr         (jr),
      .alu_ctrl   (alu_ctrl),
      .pc_branch  (pc_branch),
      .pc_src     (pc_src),
      .read_data  (read_data)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   wire [12:0] dut_ctrl = {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg,
                           jump, jal, jr, alu_ctrl};

   // Control word: {reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg,
   //                jump, jal, jr, alu_ctrl[3:0]}, written straight from the op table.
   function automatic logic [12:0] model_ctrl(input logic [5:0] o, input logic [5:0] f);
      logic [8:0] b;
      logic [3:0] a;
      b = 9'b0;
      a = 4'b0010;
      case (o)
         6'h00: begin
            case (f)
               6'h20: begin b = 9'b110000000; a = 4'b0010; end
               6'h22: begin b = 9'b110000000; a = 4'b0110; end
               6'h24: begin b = 9'b110000000; a = 4'b0000; end
               6'h25: begin b = 9'b110000000; a = 4'b0001; end
               6'h27: begin b = 9'b110000000; a = 4'b1100; end
               6'h2a: begin b = 9'b110000000; a = 4'b0111; end
               6'h08: b = 9'b000000001;
               default: ;
            endcase
         end
         6'h23: b = 9'b101001000;
         6'h2b: b = 9'b001010000;
         6'h04: begin b = 9'b000100000; a = 4'b0110; end
         6'h08: begin b = 9'b101000000; a = 4'b0010; end
         6'h0c: begin b = 9'b101000000; a = 4'b0000; end
         6'h0d: begin b = 9'b101000000; a = 4'b0001; end
         6'h0a: begin b = 9'b101000000; a = 4'b0111; end
         6'h02: b = 9'b000000100;
         6'h03: b = 9'b100000110;
         default: ;
      endcase
      return {b, a};
   endfunction

   function automatic int word_idx(input logic [N-1:0] addr);
      return int'((addr >> 2) % DEPTH);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
      end
   endtask

   // Memory model update on each rising edge.
   always @(posedge CLK) begin
      logic [12:0] c;
      c = model_ctrl(op, funct);
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) model_mem[i] <= '0;
         model_ready <= 1'b1;
      end else if (c[8]) begin
         model_mem[word_idx(alu_out)] <= write_data;
      end
   end

   // Per-cycle comparison away from the active edge.
   always @(negedge CLK) begin
      logic [N-1:0] exp_br;
      logic [12:0]  c;
      if (model_ready) begin
         c      = model_ctrl(op, funct);
         exp_br = pc_plus_4 + signimm * 4;
         check("ctrl", 64'(dut_ctrl), 64'(c));
         check("pc_branch", 64'(pc_branch), 64'(exp_br));
         check("pc_src", 64'(pc_src), 64'(c[9] & zero_flag));
         check("read_data", 64'(read_data), 64'(model_mem[word_idx(alu_out)]));
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   logic [5:0] op_tab [10] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h08, 6'h0c, 6'h0d, 6'h0a,
                               6'h02, 6'h03};
   logic [5:0] fn_tab [7]  = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2a, 6'h08};

   initial begin
      rst        = 1'b0;
      op         = 6'h2b;
      funct      = 6'h00;
      zero_flag  = 1'b0;
      pc_plus_4  = '0;
      signimm    = '0;
      alu_out    = 32'h0000000C;
      write_data = 32'hFFFFFFFF;
      tick();
      rst = 1'b1;
      op  = 6'h23;
      #2 check("reset_clears_0x0C", 64'(read_data), 64'h0);
      alu_out = 32'h0;
      #1 check("reset_clears_0x00", 64'(read_data), 64'h0);

      // R-type SUB
      op = 6'h00; funct = 6'h22;
      #1 check("rtype_sub", 64'(dut_ctrl), 64'({9'b110000000, 4'b0110}));

      // beq target and pc_src
      op = 6'h04; zero_flag = 1'b1; pc_plus_4 = 32'h00000010; signimm = 32'hFFFFFFFE;
      #1 check("beq_target", 64'(pc_branch), 64'h00000008);
      check("beq_taken", 64'(pc_src), 64'h1);
      zero_flag = 1'b0;
      #1 check("beq_not_taken", 64'(pc_src), 64'h0);

      // jal, jr, undefined op
      op = 6'h03;
      #1 check("jal", 64'(dut_ctrl), 64'({9'b100000110, 4'b0010}));
      op = 6'h00; funct = 6'h08;
      #1 check("jr", 64'(dut_ctrl), 64'({9'b000000001, 4'b0010}));
      op = 6'h3f;
      #1 check("undef_op", 64'(dut_ctrl), 64'({9'b000000000, 4'b0010}));

      // store then load at 0x0C
      tick();
      op = 6'h2b; alu_out = 32'h0000000C; write_data = 32'hDEADBEEF;
      #1 check("read_before_write", 64'(read_data), 64'h0);
      tick();
      op = 6'h23;
      #1 check("lw_after_sw", 64'(read_data), 64'hDEADBEEF);
      check("lw_mem_to_reg", 64'(mem_to_reg), 64'h1);

      // address aliasing: 0x100 maps onto word 0
      op = 6'h2b; alu_out = 32'h00000100; write_data = 32'h12345678;
      tick();
      op = 6'h23; alu_out = 32'h00000000;
      #1 check("alias_read", 64'(read_data), 64'h12345678);

      // reset with sw decoded: clear wins
      op = 6'h2b; alu_out = 32'h0000000C; write_data = 32'hCAFEF00D; rst = 1'b0;
      tick();
      rst = 1'b1; op = 6'h23;
      #1 check("reset_over_sw", 64'(read_data), 64'h0);
      alu_out = 32'h0;
      #1 check("reset_clears_alias", 64'(read_data), 64'h0);

      // randomized traffic
      for (int cyc = 0; cyc < 3000; cyc++) begin
         tick();
         begin
            int k;
            k = int'($urandom_range(0, 11));
            op = (k < 10) ? op_tab[k] : 6'($urandom);
            k = int'($urandom_range(0, 9));
            funct = (k < 7) ? fn_tab[k] : 6'($urandom);
         end
         rst        = ($urandom_range(0, 39) != 0);
         zero_flag  = 1'($urandom);
         pc_plus_4  = $urandom;
         signimm    = $urandom;
         write_data = $urandom;
         alu_out    = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h000003FF);
      end
      tick();
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/control_mem_block.md
CONTROL_MEM_BLOCK -- requirements
Module: control_mem_block

Interface
REQ-001 Parameter N, default 32, datapath word width in bits.
REQ-002 Parameter DEPTH, default 64, number of data-memory words (power of two).
REQ-003 Ports:
- CLK  in  1  sole clock; rising edge.
- rst  in  1  reset; synchronous, active-low.
- op  in  6  instruction opcode, instr[31:26].
- funct  in  6  R-type function field, instr[5:0].
- zero_flag  in  1  ALU zero result.
- pc_plus_4  in  N  PC + 4.
- signimm  in  N  sign-extended immediate.
- alu_out  in  N  memory byte address.
- write_data  in  N  store data.
- reg_write, reg_dst, alu_src, branch, mem_write, mem_to_reg, jump, jal, jr  out  1 each  control lines.
- alu_ctrl  out  4  ALU operation.
- pc_branch  out  N  branch target.
- pc_src  out  1  take-branch select.
- read_data  out  N  memory read data.

Function
REQ-004 Decode SHALL be purely combinational from op/funct, zero latency.
REQ-005 alu_ctrl encoding SHALL be: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
REQ-006 op 000000 (R-type): reg_write=1, reg_dst=1, others 0; funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 100111 NOR, 101010 SLT.
REQ-007 op 000000 with funct 001000 (jr): jr=1, reg_write=0, all other controls 0, alu_ctrl ADD.
REQ-008 lw 100011: reg_write, alu_src, mem_to_reg = 1; ADD.
REQ-009 sw 101011: alu_src, mem_write = 1; ADD.
REQ-010 beq 000100: branch=1; SUB.
REQ-011 addi 001000 ADD, andi 001100 AND, ori 001101 OR, slti 001010 SLT: each reg_write=1, alu_src=1.
REQ-012 j 000010: jump=1. jal 000011: jump=1, jal=1, reg_write=1.
REQ-013 Any undefined op, or R-type undefined funct, SHALL drive all 1-bit controls 0 and alu_ctrl ADD.
REQ-014 pc_branch SHALL equal pc_plus_4 + (signimm shifted left 2), modulo 2^N, carry discarded.
REQ-015 pc_src SHALL equal branch AND zero_flag.
REQ-016 Memory word index SHALL be alu_out[log2(DEPTH)+1:2]; alu_out[1:0] and upper bits ignored (addresses wrap).
REQ-017 read_data SHALL be combinational from the indexed word, regardless of mem_write.
REQ-018 On rising CLK with rst=1 and mem_write=1, write_data SHALL be stored at the indexed word; read_data reflects new value after the edge (read-before-write same cycle returns old value).
REQ-019 mem_write used for the store SHALL be the decoded output of REQ-009 (internal), not an external input.

Reset
REQ-020 On rising CLK with rst=0, all memory words SHALL become 0 and any write that cycle SHALL be suppressed.
REQ-021 Reset SHALL NOT affect combinational decode, pc_branch or pc_src.
REQ-022 Reset asserted mid-sequence SHALL clear memory on that edge; deassertion takes effect at the next edge.

Structure
REQ-023 Shared package SHALL hold opcode, funct and alu_ctrl constants.
REQ-024 One sub-module, data_memory_array (storage, sync write, async read, sync clear), is natural; decode and adder stay inline.

Verification
REQ-025 op=000000, funct=100010 -> reg_write=1, reg_dst=1, alu_ctrl=0110, others 0.
REQ-026 op=000100, zero_flag=1, pc_plus_4=0x00000010, signimm=0xFFFFFFFE -> pc_branch=0x00000008, pc_src=1; zero_flag=0 -> pc_src=0.
REQ-027 sw (op 101011), alu_out=0x0C, write_data=0xDEADBEEF, one edge; then lw (op 100011) alu_out=0x0C -> read_data=0xDEADBEEF, mem_to_reg=1.
REQ-028 Alias: store 0x12345678 at alu_out=0x100 -> read at 0x000 returns 0x12345678 (DEPTH=64).
REQ-029 After REQ-027 store, rst=0 for one edge with sw still decoded -> read_data at 0x0C is 0.
REQ-030 op=000011 -> jump=1, jal=1, reg_write=1; op=000000 funct=001000 -> jr=1 only; op=111111 -> all controls 0, alu_ctrl=0010.
